lookup_sched: RTL
=================

# lookup_sched

Front-end scheduler for the 4-bit-stride trie lookup pipeline. Round-robin arbitrates up to NUM_REQ lookup requesters onto the single pipeline ingress, feeding the root stage with the top nibble, and bounds in-flight lookups with a credit counter. Routes pipeline results back to the originating requester by tag. Drains the pipeline and grants an exclusive window to the stage-RAM update controller on request.

## Interface
- NUM_REQ, 4, number of requesters (2..8)
- ADDR_WIDTH, 32, lookup key width; multiple of 4
- MAX_INFLIGHT, 8, credit limit on in-flight lookups (1..15)
- TAG_WIDTH, log2(NUM_REQ), result routing tag width

- clk  in  1  clock, all logic on rising edge
- rst  in  1  synchronous, active-low reset
- req_valid  in  NUM_REQ  per-requester request valid
- req_addr  in  NUM_REQ*ADDR_WIDTH  packed keys, requester i at [i*ADDR_WIDTH +: ADDR_WIDTH]
- req_ready  out  NUM_REQ  one-hot accept, combinational
- pipe_valid  out  1  issue strobe to pipeline
- pipe_stride  out  4  key[ADDR_WIDTH-1 -: 4], root-stage address
- pipe_key  out  ADDR_WIDTH  full key carried down the pipeline
- pipe_tag  out  TAG_WIDTH  index of issuing requester
- res_valid  in  1  pipeline result strobe
- res_tag  in  TAG_WIDTH  tag returned with result
- res_nexthop  in  8  result next hop (0 = no match)
- rsp_valid  out  NUM_REQ  one-hot response strobe
- rsp_nexthop  out  8  shared next-hop bus
- upd_req  in  1  update controller requests RAM window (level)
- upd_gnt  out  1  window granted; pipeline empty, no issue
- inflight  out  4  current credit-in-use count

## Operation
- FSM states: ISSUE, DRAIN, UPDATE. Reset state ISSUE.
- ISSUE: if upd_req=1 -> DRAIN (no issue that cycle). Otherwise, if inflight < MAX_INFLIGHT, grant the first requester with req_valid=1 searching from rr_ptr upward, wrapping at NUM_REQ-1 -> 0; req_ready one-hot to winner, all zero if no valid or no credit.
- On accept (req_valid[i] & req_ready[i]): register key, stride, tag=i; pipe_valid=1 next cycle; rr_ptr <= (i+1) mod NUM_REQ. rr_ptr unchanged when no accept.
- DRAIN: req_ready=0; when inflight==0 and no pipe_valid pending -> UPDATE.
- UPDATE: upd_gnt=1, req_ready=0; when upd_req=0 -> ISSUE (upd_gnt drops same transition).
- Credits: inflight +1 on accept, -1 on res_valid, unchanged when both in the same cycle. res_valid at inflight==0 is a protocol error: counter saturates at 0, flagged by bench assertion.
- Response: on res_valid, rsp_valid[res_tag]=1 and rsp_nexthop=res_nexthop next cycle. Results are processed in all states, including DRAIN and UPDATE.
- res_tag >= NUM_REQ: rsp_valid stays 0, credit still released.

## Timing
- Reset values: req_ready=0, pipe_valid=0, pipe_stride=0, pipe_key=0, pipe_tag=0, rsp_valid=0, rsp_nexthop=0, upd_gnt=0, inflight=0, rr_ptr=0, state ISSUE.
- Accept cycle N -> pipe_valid in cycle N+1, one cycle wide.
- res_valid cycle M -> rsp_valid in cycle M+1, one cycle wide.
- Max issue rate: one per cycle while credits remain.
- upd_req rising with a pending accept in the same cycle: the update request takes priority and no accept occurs.
- upd_gnt asserts no earlier than one cycle after inflight reaches 0.
- Reset mid-operation discards all state; outstanding results arriving after reset are treated as credit-less (saturate at 0).

## Structure
- Shared package lookup_pkg: stride width 4, nexthop width 8, FSM state encoding, and the log2 function.
- One sub-module: rr_arbiter (NUM_REQ requests, pointer in, one-hot grant and grant index out; combinational).

## Test plan
- Single requester 0, key 0xC0A80101, no contention -> pipe_valid next cycle, pipe_stride=0xC, pipe_tag=0. Result res_tag=0, res_nexthop=0x2A -> rsp_valid=4'b0001, rsp_nexthop=0x2A one cycle later.
- All four requesters valid continuously, credits unlimited by fast returns -> grants ordered 0,1,2,3,0,...; each requester gets exactly 25% of the accepts over 40 cycles.
- MAX_INFLIGHT=8, no results returned -> exactly 8 accepts, then req_ready=0. One res_valid -> exactly one further accept. Simultaneous accept + res_valid leaves inflight unchanged.
- 5 in flight, raise upd_req -> no new accepts. upd_gnt asserts after the 5th result. Drop upd_req -> next cycle ISSUE, accepts resume from the saved rr_ptr.
- res_tag=3 with NUM_REQ=3 -> no rsp_valid, inflight decrements.
- Assert rst=0 with 4 in flight and upd_req high -> all outputs at reset values next cycle; state ISSUE, upd_gnt=0.

Source files
------------

// File: rtl/lookup_pkg.sv
// Shared definitions for the trie lookup front-end: field widths, scheduler
// state encoding and a ceiling-log2 helper for tag sizing.
package lookup_pkg;

  localparam int unsigned StrideWidth  = 4;
  localparam int unsigned NexthopWidth = 8;

  typedef enum logic [1:0] {
    StIssue  = 2'd0,
    StDrain  = 2'd1,
    StUpdate = 2'd2
  } sched_state_e;

  // Ceiling log2, never below 1 so a tag always has at least one bit.
  function automatic int unsigned log2(input int unsigned n);
    int unsigned r;
    r = 1;
    for (int unsigned i = 1; i < 32; i++) begin
      if ((32'd1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin arbiter: first asserted request at or above the
// pointer, wrapping at NumReq-1 back to 0.
module rr_arbiter
  import lookup_pkg::*;
#(
  parameter int unsigned NumReq   = 4,
  parameter int unsigned IdxWidth = log2(NumReq)
) (
  input  logic [NumReq-1:0]   req_i,
  input  logic [IdxWidth-1:0] ptr_i,
  output logic [NumReq-1:0]   gnt_o,
  output logic [IdxWidth-1:0] idx_o,
  output logic                valid_o
);

  always_comb begin
    int unsigned          cand;
    logic [IdxWidth-1:0]  cand_idx;
    cand     = 0;
    cand_idx = '0;
    gnt_o    = '0;
    idx_o    = '0;
    valid_o  = 1'b0;
    for (int unsigned off = 0; off < NumReq; off++) begin
      cand     = (32'(ptr_i) + off) % NumReq;
      cand_idx = IdxWidth'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o         = 1'b1;
        gnt_o[cand_idx] = 1'b1;
        idx_o           = cand_idx;
      end
    end
  end

endmodule

// File: rtl/lookup_sched.sv
// Front-end scheduler for the trie lookup pipeline: round-robin issue under a
// credit limit, tag-routed result return, and drain/grant for RAM updates.
module lookup_sched
  import lookup_pkg::*;
#(
  parameter int unsigned NUM_REQ      = 4,
  parameter int unsigned ADDR_WIDTH   = 32,
  parameter int unsigned MAX_INFLIGHT = 8,
  parameter int unsigned TAG_WIDTH    = log2(NUM_REQ)
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [NUM_REQ-1:0]            req_valid,
  input  logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr,
  output logic [NUM_REQ-1:0]            req_ready,
  output logic                          pipe_valid,
  output logic [StrideWidth-1:0]        pipe_stride,
  output logic [ADDR_WIDTH-1:0]         pipe_key,
  output logic [TAG_WIDTH-1:0]          pipe_tag,
  input  logic                          res_valid,
  input  logic [TAG_WIDTH-1:0]          res_tag,
  input  logic [NexthopWidth-1:0]       res_nexthop,
  output logic [NUM_REQ-1:0]            rsp_valid,
  output logic [NexthopWidth-1:0]       rsp_nexthop,
  input  logic                          upd_req,
  output logic                          upd_gnt,
  output logic [3:0]                    inflight
);

  sched_state_e              state_q, state_d;
  logic [TAG_WIDTH-1:0]      rr_ptr_q, rr_ptr_d;
  logic [3:0]                inflight_q, inflight_d;
  logic                      pipe_valid_q, pipe_valid_d;
  logic [ADDR_WIDTH-1:0]     pipe_key_q, pipe_key_d;
  logic [TAG_WIDTH-1:0]      pipe_tag_q, pipe_tag_d;
  logic [NUM_REQ-1:0]        rsp_valid_q, rsp_valid_d;
  logic [NexthopWidth-1:0]   rsp_nexthop_q, rsp_nexthop_d;

  logic [NUM_REQ-1:0]        arb_gnt;
  logic [TAG_WIDTH-1:0]      arb_idx;
  logic                      arb_valid;
  logic                      can_issue;
  logic                      accept;
  logic [ADDR_WIDTH-1:0]     win_key;

  rr_arbiter #(
    .NumReq   (NUM_REQ),
    .IdxWidth (TAG_WIDTH)
  ) u_rr_arbiter (
    .req_i   (req_valid),
    .ptr_i   (rr_ptr_q),
    .gnt_o   (arb_gnt),
    .idx_o   (arb_idx),
    .valid_o (arb_valid)
  );

  // An update request blocks issue in the same cycle it appears.
  always_comb begin
    can_issue = rst && (state_q == StIssue) && !upd_req &&
                (inflight_q < 4'(MAX_INFLIGHT));
    req_ready = can_issue ? arb_gnt : '0;
    accept    = can_issue && arb_valid;
    win_key   = '0;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (arb_idx == TAG_WIDTH'(i)) win_key = req_addr[i*ADDR_WIDTH +: ADDR_WIDTH];
    end
  end

  always_comb begin
    rr_ptr_d     = rr_ptr_q;
    pipe_valid_d = accept;
    pipe_key_d   = pipe_key_q;
    pipe_tag_d   = pipe_tag_q;
    if (accept) begin
      pipe_key_d = win_key;
      pipe_tag_d = arb_idx;
      rr_ptr_d   = (arb_idx == TAG_WIDTH'(NUM_REQ - 1)) ? '0 : arb_idx + 1'b1;
    end
  end

  // Credit release saturates at zero; a simultaneous accept and release cancel.
  always_comb begin
    inflight_d = inflight_q;
    if (accept && !res_valid) begin
      inflight_d = inflight_q + 4'd1;
    end else if (!accept && res_valid && (inflight_q != 4'd0)) begin
      inflight_d = inflight_q - 4'd1;
    end
  end

  // Out-of-range tags match no requester, so no response strobe fires.
  always_comb begin
    rsp_valid_d   = '0;
    rsp_nexthop_d = res_valid ? res_nexthop : rsp_nexthop_q;
    for (int unsigned i = 0; i < NUM_REQ; i++) begin
      if (res_tag == TAG_WIDTH'(i)) rsp_valid_d[i] = res_valid;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIssue:  if (upd_req) state_d = StDrain;
      StDrain:  if ((inflight_q == 4'd0) && !pipe_valid_q) state_d = StUpdate;
      StUpdate: if (!upd_req) state_d = StIssue;
      default:  state_d = StIssue;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q       <= StIssue;
      rr_ptr_q      <= '0;
      inflight_q    <= '0;
      pipe_valid_q  <= 1'b0;
      pipe_key_q    <= '0;
      pipe_tag_q    <= '0;
      rsp_valid_q   <= '0;
      rsp_nexthop_q <= '0;
    end else begin
      state_q       <= state_d;
      rr_ptr_q      <= rr_ptr_d;
      inflight_q    <= inflight_d;
      pipe_valid_q  <= pipe_valid_d;
      pipe_key_q    <= pipe_key_d;
      pipe_tag_q    <= pipe_tag_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_nexthop_q <= rsp_nexthop_d;
    end
  end

  assign pipe_valid  = pipe_valid_q;
  assign pipe_key    = pipe_key_q;
  assign pipe_stride = pipe_key_q[ADDR_WIDTH-1 -: StrideWidth];
  assign pipe_tag    = pipe_tag_q;
  assign rsp_valid   = rsp_valid_q;
  assign rsp_nexthop = rsp_nexthop_q;
  assign upd_gnt     = (state_q == StUpdate);
  assign inflight    = inflight_q;

endmodule
